// File: rtl/manchester_framer_pkg.sv
// rtl/manchester_framer_pkg.sv - shared constants and state encoding for the Manchester framer
//
// Holds the default preamble/SFD patterns, the CRC-8 polynomial and the
// framer state encoding so that neighbouring Manchester blocks agree on them.
package manchester_framer_pkg;

  localparam logic [7:0] PREAMBLE_BYTE_DEF = 8'hAA;
  localparam logic [7:0] SFD_BYTE_DEF      = 8'hD5;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_CRC      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_GAP      = 3'd6
  } state_t;

endpackage

// File: rtl/manchester_crc8.sv
// rtl/manchester_crc8.sv - combinational CRC-8 byte update
//
// Ports:
//   crc_in  [7:0]  running CRC before this byte
//   data    [7:0]  byte folded into the CRC
//   crc_out [7:0]  running CRC after this byte
// Polynomial x^8+x^2+x+1 (0x07), MSB first, no reflection.
module manchester_crc8
  import manchester_framer_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  // Fold the whole byte in first, then shift out eight bits; equivalent to
  // the bit-serial register because the polynomial has no x^8 term stored.
  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/manchester_framer.sv
// rtl/manchester_framer.sv - wraps payload packets in preamble, SFD and idle gap
//
// Optional feature macro: MANCHESTER_FRAMER_CRC8_EN appends a CRC-8 byte
// computed over the emitted payload bytes.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axis_t*            payload byte stream in, packets delimited by tlast
//   m_axis_t*            framed byte stream out (single output register)
//   busy                 high whenever the FSM is not idle
//   frame_err            one-cycle pulse when a payload is truncated
module manchester_framer
  import manchester_framer_pkg::*;
#(
  parameter int         PREAMBLE_LEN  = 2,
  parameter logic [7:0] PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter logic [7:0] SFD_BYTE      = SFD_BYTE_DEF,
  parameter int         IFG_CYCLES    = 16,
  parameter int         MAX_PAYLOAD   = 255
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  output logic       busy,
  output logic       frame_err
);

  state_t      state, state_n;
  logic [3:0]  pre_cnt;
  logic [7:0]  byte_cnt;
  logic [15:0] gap_cnt;

  logic        load_ok;
  logic        ld;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        s_ready;
  logic        accept;
  logic        trunc_ev;

`ifdef MANCHESTER_FRAMER_CRC8_EN
  logic [7:0]  crc_q;
  logic [7:0]  crc_nxt;
  logic        trunc_q;

  manchester_crc8 u_crc8 (
    .crc_in  (crc_q),
    .data    (s_axis_tdata),
    .crc_out (crc_nxt)
  );
`endif

  // The output register can take a new byte when empty or draining this cycle.
  assign load_ok       = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_ready && s_axis_tvalid;
  assign s_axis_tready = s_ready;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    s_ready  = 1'b0;
    trunc_ev = 1'b0;
    case (state)
      ST_IDLE: begin
        // The waiting payload byte is only observed here, never consumed.
        if (s_axis_tvalid && load_ok) begin
          ld      = 1'b1;
          ld_data = PREAMBLE_BYTE;
          state_n = (PREAMBLE_LEN == 1) ? ST_SFD : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = PREAMBLE_BYTE;
          if (pre_cnt == 4'(PREAMBLE_LEN - 1)) state_n = ST_SFD;
        end
      end
      ST_SFD: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = SFD_BYTE;
          state_n = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        s_ready = load_ok;
        if (s_axis_tvalid && load_ok) begin
          ld      = 1'b1;
          ld_data = s_axis_tdata;
          if (!s_axis_tlast && byte_cnt == 8'(MAX_PAYLOAD - 1)) trunc_ev = 1'b1;
`ifdef MANCHESTER_FRAMER_CRC8_EN
          ld_last = 1'b0;
          if (s_axis_tlast || trunc_ev) state_n = ST_CRC;
`else
          if (s_axis_tlast) begin
            ld_last = 1'b1;
            state_n = ST_GAP;
          end else if (trunc_ev) begin
            ld_last = 1'b1;
            state_n = ST_DRAIN;
          end
`endif
        end
      end
`ifdef MANCHESTER_FRAMER_CRC8_EN
      ST_CRC: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = crc_q;
          ld_last = 1'b1;
          state_n = trunc_q ? ST_DRAIN : ST_GAP;
        end
      end
`endif
      ST_DRAIN: begin
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_n = ST_GAP;
      end
      ST_GAP: begin
        // Idle cycles are counted only once the final byte has left; the
        // IDLE cycle that follows supplies the last idle cycle of the gap.
        if (m_axis_tvalid) begin
          if (m_axis_tready && IFG_CYCLES <= 1) state_n = ST_IDLE;
        end else if ((int'(gap_cnt) + 1) >= (IFG_CYCLES - 1)) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_err     <= 1'b0;
      pre_cnt       <= 4'd0;
      byte_cnt      <= 8'd0;
      gap_cnt       <= 16'd0;
    end else begin
      state     <= state_n;
      frame_err <= trunc_ev;

      if (ld) begin
        m_axis_tdata  <= ld_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= ld_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (state == ST_IDLE) begin
        pre_cnt  <= ld ? 4'd1 : 4'd0;
        byte_cnt <= 8'd0;
      end else if (state == ST_PREAMBLE && ld) begin
        pre_cnt <= pre_cnt + 4'd1;
      end else if (state == ST_PAYLOAD && accept && byte_cnt != 8'hFF) begin
        byte_cnt <= byte_cnt + 8'd1;
      end

      if (state != ST_GAP)     gap_cnt <= 16'd0;
      else if (!m_axis_tvalid) gap_cnt <= gap_cnt + 16'd1;
    end
  end

`ifdef MANCHESTER_FRAMER_CRC8_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      crc_q   <= 8'h00;
      trunc_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      crc_q   <= 8'h00;
      trunc_q <= 1'b0;
    end else if (state == ST_PAYLOAD && accept) begin
      crc_q <= crc_nxt;
      if (trunc_ev) trunc_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_manchester_framer.sv
// tb/tb_manchester_framer.sv - scoreboard bench for manchester_framer
`timescale 1ns/1ps
module tb_manchester_framer;

  localparam int PRE  = 2;
  localparam int IFG  = 16;
  localparam int MAXP = 4;

  typedef logic [7:0] bq_t[$];

  logic       aclk;
  logic       aresetn;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready;
  logic       busy;
  logic       frame_err;

  manchester_framer #(
    .PREAMBLE_LEN  (PRE),
    .PREAMBLE_BYTE (8'hAA),
    .SFD_BYTE      (8'hD5),
    .IFG_CYCLES    (IFG),
    .MAX_PAYLOAD   (MAXP)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  bit         rand_ready     = 1'b0;
  bit         gap_exact      = 1'b0;
  bit         chk_no_consume = 1'b0;
  int         err_cycles     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_ref(input bq_t d, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ d[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic push_expect(input bq_t d, input int n_emit);
    for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hD5});
`ifdef MANCHESTER_FRAMER_CRC8_EN
    for (int i = 0; i < n_emit; i++) exp_q.push_back({1'b0, d[i]});
    exp_q.push_back({1'b1, crc_ref(d, n_emit)});
`else
    for (int i = 0; i < n_emit; i++) exp_q.push_back({(i == n_emit - 1), d[i]});
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic hs;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk);
      #1;
      if (hs) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_pkt(input bq_t d, input bit hold);
    for (int i = 0; i < d.size(); i++) send_byte(d[i], (i == d.size() - 1));
    if (!hold) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 1000 && (exp_q.size() != 0 || busy); k++) @(posedge aclk);
    #1;
    check({nm, "_drained"}, exp_q.size(), 0);
    check({nm, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_m_tvalid"}, m_axis_tvalid, 1'b0);
    check({nm, "_m_tlast"},  m_axis_tlast, 1'b0);
    check({nm, "_m_tdata"},  m_axis_tdata, 8'h00);
    check({nm, "_s_tready"}, s_axis_tready, 1'b0);
    check({nm, "_busy"},     busy, 1'b0);
    check({nm, "_frame_err"}, frame_err, 1'b0);
  endtask

  // m-side ready driver
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, gap length, frame_err width
  bit         in_gap = 1'b0;
  bit         gap_mode = 1'b0;
  int         gap_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_out;
  logic [8:0] got;
  logic [8:0] exp;

  always @(negedge aclk) begin
    if (!aresetn) begin
      in_gap     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_out});
      end
      if (in_gap) begin
        if (m_axis_tvalid) begin
          if (gap_mode) check("gap_exact", gap_cnt, IFG);
          else          check("gap_min", (gap_cnt >= IFG), 1'b1);
          in_gap = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got = {m_axis_tlast, m_axis_tdata};
        if (exp_q.size() == 0) begin
          check("unexpected_out", got, 9'h1FF);
        end else begin
          exp = exp_q.pop_front();
          check("out_byte", got, exp);
        end
        if (m_axis_tlast) begin
          in_gap   = 1'b1;
          gap_cnt  = 0;
          gap_mode = gap_exact;
        end
      end
      if (chk_no_consume && s_axis_tvalid && s_axis_tready) begin
        check("consume_while_stalled", (m_axis_tvalid && !m_axis_tready), 1'b0);
      end
      if (frame_err) err_cycles++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, p2;
    int  e0;
    aresetn       = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Single packet, ready always high
    p = '{8'hF0, 8'h0F, 8'hAA};
    push_expect(p, 3);
    send_pkt(p, 1'b0);
    wait_done("single");
    repeat (IFG + 4) @(posedge aclk);
    #1;
    check("single_tvalid_low", m_axis_tvalid, 1'b0);

    // Same packet under random backpressure
    rand_ready     = 1'b1;
    chk_no_consume = 1'b1;
    push_expect(p, 3);
    send_pkt(p, 1'b0);
    wait_done("backpressure");
    rand_ready     = 1'b0;
    chk_no_consume = 1'b0;

    // Back-to-back packets: exact gap between them
    p  = '{8'h11};
    p2 = '{8'h22, 8'h33};
    push_expect(p, 1);
    push_expect(p2, 2);
    send_pkt(p, 1'b1);
    gap_exact = 1'b1;
    send_pkt(p2, 1'b0);
    gap_exact = 1'b0;
    wait_done("b2b");

    // Truncation at MAX_PAYLOAD, then a normal packet
    p  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    e0 = err_cycles;
    push_expect(p, MAXP);
    send_pkt(p, 1'b0);
    wait_done("trunc");
    check("trunc_frame_err_cycles", err_cycles - e0, 1);
    p = '{8'h5A};
    push_expect(p, 1);
    send_pkt(p, 1'b0);
    wait_done("post_trunc");

    // Reset in the middle of a payload
    p = '{8'hA1, 8'hA2, 8'hA3};
    push_expect(p, 3);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    p = '{8'h5A};
    push_expect(p, 1);
    send_pkt(p, 1'b0);
    wait_done("post_reset");

`ifdef MANCHESTER_FRAMER_CRC8_EN
    // Hand-computed CRC of a single 0x01 byte is 0x07
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h07});
    p = '{8'h01};
    send_pkt(p, 1'b0);
    wait_done("crc_01");
`else
    // Hand-coded single-byte frame: preamble, SFD, payload carrying tlast
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b1, 8'h01});
    p = '{8'h01};
    send_pkt(p, 1'b0);
    wait_done("one_byte");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/manchester_framer.md
Name: manchester_framer

Overview:
Byte-stream framer that sits directly upstream of manchester_serializer. It accepts payload packets on AXI-Stream, each delimited by tlast. For each packet it emits PREAMBLE_LEN preamble bytes, then the SFD byte, then the payload, followed by a mandatory line-idle gap. This gives the downstream manchester_decoder a preamble to lock onto and an SFD marking the start of payload.

Parameters:
PREAMBLE_LEN, 2, number of PREAMBLE_BYTE bytes sent before the SFD (range 1..15)
PREAMBLE_BYTE, 8'hAA, preamble pattern
SFD_BYTE, 8'hD5, start-of-frame delimiter
IFG_CYCLES, 16, minimum idle cycles with m_axis_tvalid low after a frame's final byte handshake (≥1)
MAX_PAYLOAD, 255, maximum payload bytes per frame (1..255)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  8  payload byte
s_axis_tvalid  in  1  payload valid
s_axis_tlast  in  1  last payload byte of packet
s_axis_tready  out  1  payload accepted
m_axis_tdata  out  8  framed byte to serializer
m_axis_tvalid  out  1  framed byte valid
m_axis_tlast  out  1  final byte of frame
m_axis_tready  in  1  serializer ready
busy  out  1  high in every state except IDLE
frame_err  out  1  one-cycle pulse on payload truncation

Behaviour:
- Reset (async assert, sync release): state=IDLE; m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, frame_err=0; m_axis_tdata=8'h00; all counters=0. A reset mid-frame discards the partial frame, with no tail bytes emitted.
- Output stage: m_axis_* is a single register. tdata/tlast hold stable while tvalid&&!tready. A new byte loads when !m_axis_tvalid || m_axis_tready.
- State machine: IDLE -> PREAMBLE -> SFD -> PAYLOAD -> [CRC] -> GAP -> IDLE. DRAIN is entered from PAYLOAD on truncation.
- IDLE: s_axis_tready=0. When s_axis_tvalid=1 (byte not consumed), go to PREAMBLE. m_axis_tvalid rises on the next cycle with PREAMBLE_BYTE.
- PREAMBLE: emit PREAMBLE_BYTE PREAMBLE_LEN times, counting m-side handshakes. Then go to SFD.
- SFD: emit SFD_BYTE once, then go to PAYLOAD.
- PAYLOAD: s_axis_tready = (!m_axis_tvalid || m_axis_tready). Each s-handshake loads the byte into the output register with zero added latency beyond the register. The byte counter increments, 8-bit saturating.
- Payload end: s_axis_tlast on a handshake sets m_axis_tlast (or goes to CRC when the feature is enabled).
- Truncation: the MAX_PAYLOAD-th accepted byte without tlast is forced to be last (m_axis_tlast=1). frame_err pulses for one cycle, then go to DRAIN.
- DRAIN: s_axis_tready=1; input bytes are discarded up to and including the tlast byte, then go to GAP. Nothing is emitted.
- GAP: entered on the handshake of the frame's final byte. m_axis_tvalid=0 and s_axis_tready=0 for IFG_CYCLES cycles, then return to IDLE.
- Back-to-back packets: the next packet's first byte waits in IDLE. Its tvalid may be high throughout GAP.
- Boundary case: a 1-byte payload with tlast yields PREAMBLE_LEN+2 bytes, or +3 with CRC.
- Simultaneous events: input is never consumed outside PAYLOAD/DRAIN. m_axis_tready toggling mid-preamble only stalls the counter.

Optional Feature:
MANCHESTER_FRAMER_CRC8_EN:
- Defined: a CRC-8 is computed over payload bytes only, as emitted (poly 0x07, init 0x00, MSB-first, no reflect, no xorout). It is appended as one extra byte in state CRC, carrying m_axis_tlast; the payload last byte has m_axis_tlast=0.
- Defined, truncation case: the CRC covers the bytes emitted.
- Undefined: CRC state and logic are absent, and the final payload byte carries tlast.

Decomposition:
- Shared header/package manchester_defs.vh holds the PREAMBLE_BYTE/SFD_BYTE defaults (8'hAA/8'hD5), the state encodings, and CRC8_POLY=8'h07. The serializer and decoder benches use the same header.
- One natural sub-module, manchester_crc8: a combinational next-CRC from (crc_in[7:0], data[7:0]), instantiated only under the macro.

Test Plan:
- Single packet {F0,0F,AA}, tlast on AA, m_axis_tready=1 -> m stream AA,AA,D5,F0,0F,AA with tlast only on the final AA; m_axis_tvalid then low ≥16 cycles; busy low afterwards.
- Backpressure: same packet with m_axis_tready pseudo-random 50% -> identical byte sequence; tdata stable during every stall; no input byte consumed while stalled.
- Back-to-back packets {11} and {22,33} presented continuously -> AA,AA,D5,11(tlast), gap of exactly 16 idle cycles, AA,AA,D5,22,33(tlast).
- Truncation with MAX_PAYLOAD=4: 6-byte packet 01..06 -> emits 01..04 with tlast on 04; frame_err pulses once; 05,06 accepted and dropped; next packet framed normally.
- Reset mid-payload after 2 bytes -> outputs go to reset values immediately; after release, a new packet {5A} is framed correctly from its preamble.
- CRC (macro defined): payload {01} -> AA,AA,D5,01,07(tlast); payload {F0,0F,AA} -> the CRC byte matches the reference model.
